lj16_stereo_deserializer: RTL and testbench

Downstream consumer of the 32fs 16-bit left-justified stream produced by the I2S-to-16LJ converter. Samples data/lrck on rising bck and assembles 16-bit MSB-first words per channel. Pairs each left and right word into one stereo sample and buffers the samples in a small FIFO with a valid/ready interface to the DAC/DSP side. Flags framing errors and overflow.

---
 rtl/lj16_pkg.sv | 16 +
 rtl/lj16_stereo_fifo.sv | 55 +++++
 rtl/lj16_stereo_deserializer.sv | 124 ++++++++++++
 tb/tb_lj16_stereo_deserializer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lj16_pkg.sv
// Shared types for the 16-bit left-justified stereo receive path.
package lj16_pkg;

  localparam int LJ_WORD_W = 16;

  typedef struct packed {
    logic [LJ_WORD_W-1:0] left;
    logic [LJ_WORD_W-1:0] right;
  } stereo_t;

  typedef enum logic {
    UNSYNCED = 1'b0,
    SYNCED   = 1'b1
  } sync_state_t;

endpackage

// File: rtl/lj16_stereo_fifo.sv
// Show-ahead stereo-sample FIFO; push while full succeeds only alongside a pop.
module lj16_stereo_fifo
  import lj16_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  stereo_t                push_data_i,
  input  logic                   pop_i,
  output stereo_t                head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  stereo_t       mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] last_ptr;
  logic [AW:0]   level_q;
  logic          do_push;
  logic          do_pop;

  assign full_o   = (level_q == FULL_LVL);
  assign empty_o  = (level_q == '0);
  assign level_o  = level_q;
  assign do_pop   = pop_i && !empty_o;
  assign do_push  = push_i && (!full_o || do_pop);
  assign last_ptr = rd_ptr_q - 1'b1;

  // When empty, the slot just behind the read pointer is the last sample popped.
  assign head_o = empty_o ? mem_q[last_ptr] : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/lj16_stereo_deserializer.sv
// Receives a 32fs 16-bit left-justified stream, pairs L/R words and queues stereo samples.
// Handshake: a sample leaves when out_valid && out_ready are both high at a rising bck.
module lj16_stereo_deserializer
  import lj16_pkg::*;
#(
  parameter int   WORD_W   = LJ_WORD_W,
  parameter int   DEPTH    = 4,
  parameter logic LEFT_POL = 1'b0
) (
  input  logic                   bck,
  input  logic                   rst_n,
  input  logic                   data,
  input  logic                   lrck,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORD_W-1:0]      out_left,
  output logic [WORD_W-1:0]      out_right,
  input  logic                   err_clr,
  output logic                   frame_err,
  output logic                   ovf_err,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   dbg_synced
);

  localparam int            CW       = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WORD_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(WORD_W - 1);

  sync_state_t       state_q;
  logic              lrck_q;
  logic [CW-1:0]     bit_cnt_q;
  logic [WORD_W-1:0] shift_q;
  logic              chan_left_q;
  logic              done_q;
  logic              done_left_q;
  logic [WORD_W-1:0] left_hold_q;
  logic              left_hold_valid_q;
  logic              frame_err_q, frame_err_d;
  logic              ovf_err_q, ovf_err_d;

  logic    lrck_edge;
  logic    short_frame;
  logic    pair_push;
  logic    pop;
  logic    fifo_full;
  logic    fifo_empty;
  stereo_t push_data;
  stereo_t head;

  assign lrck_edge   = lrck ^ lrck_q;
  assign short_frame = lrck_edge && (state_q == SYNCED) &&
                       (bit_cnt_q != '0) && (bit_cnt_q != CNT_FULL);
  assign pair_push   = done_q && !done_left_q && left_hold_valid_q;
  assign push_data   = '{left: left_hold_q, right: shift_q};
  assign pop         = out_valid && out_ready;

  always_comb begin
    frame_err_d = (err_clr ? 1'b0 : frame_err_q) | short_frame;
    ovf_err_d   = (err_clr ? 1'b0 : ovf_err_q) | (pair_push && fifo_full && !pop);
  end

  always_ff @(posedge bck or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= UNSYNCED;
      lrck_q            <= 1'b0;
      bit_cnt_q         <= '0;
      shift_q           <= '0;
      chan_left_q       <= 1'b0;
      done_q            <= 1'b0;
      done_left_q       <= 1'b0;
      left_hold_q       <= '0;
      left_hold_valid_q <= 1'b0;
      frame_err_q       <= 1'b0;
      ovf_err_q         <= 1'b0;
    end else begin
      lrck_q      <= lrck;
      done_q      <= 1'b0;
      frame_err_q <= frame_err_d;
      ovf_err_q   <= ovf_err_d;
      if (lrck_edge) begin
        state_q     <= SYNCED;
        shift_q     <= {{(WORD_W-1){1'b0}}, data};
        bit_cnt_q   <= CW'(1);
        chan_left_q <= (lrck == LEFT_POL);
      end else if ((state_q == SYNCED) && (bit_cnt_q != CNT_FULL)) begin
        shift_q   <= {shift_q[WORD_W-2:0], data};
        bit_cnt_q <= bit_cnt_q + 1'b1;
        if (bit_cnt_q == CNT_LAST) begin
          done_q      <= 1'b1;
          done_left_q <= chan_left_q;
        end
      end
      // shift_q still holds the completed word during the done cycle.
      if (short_frame) begin
        left_hold_valid_q <= 1'b0;
      end else if (done_q && done_left_q) begin
        left_hold_q       <= shift_q;
        left_hold_valid_q <= 1'b1;
      end else if (done_q) begin
        left_hold_valid_q <= 1'b0;
      end
    end
  end

  lj16_stereo_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (bck),
    .rst_ni      (rst_n),
    .push_i      (pair_push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

  assign out_valid  = !fifo_empty;
  assign out_left   = head.left;
  assign out_right  = head.right;
  assign frame_err  = frame_err_q;
  assign ovf_err    = ovf_err_q;
  assign dbg_synced = (state_q == SYNCED);

endmodule

// File: tb/tb_lj16_stereo_deserializer.sv
// Directed bench for lj16_stereo_deserializer: framing, pairing, FIFO, flags and async reset.
module tb_lj16_stereo_deserializer;

  logic        bck;
  logic        rst_n;
  logic        data;
  logic        lrck;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_left;
  logic [15:0] out_right;
  logic        err_clr;
  logic        frame_err;
  logic        ovf_err;
  logic [2:0]  fifo_level;
  logic        dbg_synced;

  logic [31:0] exp_q[$];
  int          n_cmp;
  int          n_err;

  lj16_stereo_deserializer #(.WORD_W(16), .DEPTH(4), .LEFT_POL(1'b0)) dut (
    .bck        (bck),
    .rst_n      (rst_n),
    .data       (data),
    .lrck       (lrck),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_left   (out_left),
    .out_right  (out_right),
    .err_clr    (err_clr),
    .frame_err  (frame_err),
    .ovf_err    (ovf_err),
    .fifo_level (fifo_level),
    .dbg_synced (dbg_synced)
  );

  // clock / reset
  initial begin
    bck = 1'b0;
    forever #5 bck = ~bck;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drivers: inputs change on falling bck, the DUT samples on rising bck
  task automatic send_bit(input logic lvl, input logic d);
    @(negedge bck);
    lrck = lvl;
    data = d;
  endtask

  task automatic send_word(input logic lvl, input logic [15:0] w, input int nbits,
                           input logic [15:0] extra);
    for (int i = 0; i < nbits; i++) begin
      if (i < 16) send_bit(lvl, w[15-i]);
      else        send_bit(lvl, extra[31-i]);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_word(1'b0, l, 16, 16'h0000);
    send_word(1'b1, r, 16, 16'h0000);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge bck);
  endtask

  task automatic pulse_ready();
    @(negedge bck);
    out_ready = 1'b1;
    @(negedge bck);
    out_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge bck);
    err_clr = 1'b1;
    @(negedge bck);
    err_clr = 1'b0;
  endtask

  // scoreboard: compare the FIFO head with the oldest expected sample, then pop it
  task automatic pop_check(input string tag);
    logic [31:0] exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_data"}, {out_left, out_right}, exp);
    pulse_ready();
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    data      = 1'b0;
    lrck      = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    #1;
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_data", {out_left, out_right}, 32'd0);
    check_eq("rst_flags", {30'd0, frame_err, ovf_err}, 32'd0);
    check_eq("rst_level", {29'd0, fifo_level}, 32'd0);
    idle(3);
    rst_n = 1'b1;

    // basic pair: partial pre-sync bits and an unpaired right word are dropped
    send_word(1'b0, 16'h7F00, 7, 16'h0000);
    check_eq("t1_unsynced", {31'd0, dbg_synced}, 32'd0);
    send_word(1'b1, 16'h0BAD, 16, 16'h0000);
    check_eq("t1_synced", {31'd0, dbg_synced}, 32'd1);
    check_eq("t1_no_orphan", {29'd0, fifo_level}, 32'd0);
    send_frame(16'hA5C3, 16'h1234);
    idle(1);
    check_eq("t1_lat_n", {31'd0, out_valid}, 32'd0);
    idle(1);
    check_eq("t1_lat_n1", {31'd0, out_valid}, 32'd1);
    check_eq("t1_level", {29'd0, fifo_level}, 32'd1);
    exp_q.push_back({16'hA5C3, 16'h1234});
    pop_check("t1_pop");
    check_eq("t1_empty", {29'd0, fifo_level}, 32'd0);
    check_eq("t1_hold", {out_left, out_right}, {16'hA5C3, 16'h1234});
    check_eq("t1_noerr", {30'd0, frame_err, ovf_err}, 32'd0);

    // overflow: 6 frames into a 4-deep FIFO with no consumer
    for (int i = 1; i <= 6; i++) begin
      send_frame(16'h1100 + 16'(i), 16'h2200 + 16'(i));
      if (i <= 4) exp_q.push_back({16'h1100 + 16'(i), 16'h2200 + 16'(i)});
    end
    idle(2);
    check_eq("t2_level", {29'd0, fifo_level}, 32'd4);
    check_eq("t2_ovf", {31'd0, ovf_err}, 32'd1);
    for (int i = 0; i < 4; i++) pop_check("t2_pop");
    check_eq("t2_drained", {31'd0, out_valid}, 32'd0);
    pulse_clr();
    check_eq("t2_ovf_clr", {31'd0, ovf_err}, 32'd0);

    // short left half-frame (10 bits)
    send_word(1'b0, 16'hFFFF, 10, 16'h0000);
    send_word(1'b1, 16'h5555, 16, 16'h0000);
    idle(2);
    check_eq("t3_frame_err", {31'd0, frame_err}, 32'd1);
    check_eq("t3_no_sample", {29'd0, fifo_level}, 32'd0);
    send_frame(16'h0F0F, 16'hF0F0);
    idle(2);
    check_eq("t3_recover", {29'd0, fifo_level}, 32'd1);
    exp_q.push_back({16'h0F0F, 16'hF0F0});
    pop_check("t3_pop");
    pulse_clr();
    check_eq("t3_clr", {31'd0, frame_err}, 32'd0);

    // full FIFO with a pop exactly on the push cycle
    for (int i = 1; i <= 4; i++) begin
      send_frame(16'h3300 + 16'(i), 16'h4400 + 16'(i));
      exp_q.push_back({16'h3300 + 16'(i), 16'h4400 + 16'(i)});
    end
    idle(2);
    check_eq("t4_full", {29'd0, fifo_level}, 32'd4);
    send_frame(16'h3305, 16'h4405);
    @(negedge bck);
    check_eq("t4_head", {out_left, out_right}, exp_q.pop_front());
    out_ready = 1'b1;
    @(negedge bck);
    out_ready = 1'b0;
    exp_q.push_back({16'h3305, 16'h4405});
    check_eq("t4_level", {29'd0, fifo_level}, 32'd4);
    check_eq("t4_no_ovf", {31'd0, ovf_err}, 32'd0);
    for (int i = 0; i < 4; i++) pop_check("t4_pop");
    check_eq("t4_drained", {29'd0, fifo_level}, 32'd0);

    // 64fs: 32 bits per half-frame, only the first 16 count
    send_word(1'b0, 16'hBEEF, 32, 16'h1357);
    send_word(1'b1, 16'hCAFE, 32, 16'h2468);
    idle(1);
    check_eq("t5_level", {29'd0, fifo_level}, 32'd1);
    check_eq("t5_frame_err", {31'd0, frame_err}, 32'd0);
    exp_q.push_back({16'hBEEF, 16'hCAFE});
    pop_check("t5_pop");

    // asynchronous reset between bck edges with a stored sample and a sticky error
    send_frame(16'h1357, 16'h9BDF);
    idle(2);
    check_eq("t6_pre_level", {29'd0, fifo_level}, 32'd1);
    send_word(1'b0, 16'hAAAA, 5, 16'h0000);
    send_word(1'b1, 16'h5555, 6, 16'h0000);
    check_eq("t6_pre_err", {31'd0, frame_err}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("t6_rst_data", {out_left, out_right}, 32'd0);
    check_eq("t6_rst_flags", {30'd0, frame_err, ovf_err}, 32'd0);
    check_eq("t6_rst_level", {29'd0, fifo_level}, 32'd0);
    check_eq("t6_rst_sync", {31'd0, dbg_synced}, 32'd0);
    lrck = 1'b0;
    data = 1'b0;
    idle(2);
    rst_n = 1'b1;
    send_word(1'b0, 16'hFFFF, 8, 16'h0000);
    check_eq("t6_ignored", {31'd0, dbg_synced}, 32'd0);
    send_word(1'b1, 16'h7777, 16, 16'h0000);
    idle(1);
    check_eq("t6_orphan", {29'd0, fifo_level}, 32'd0);
    check_eq("t6_no_err", {31'd0, frame_err}, 32'd0);
    send_frame(16'h4321, 16'h8765);
    idle(2);
    exp_q.push_back({16'h4321, 16'h8765});
    pop_check("t6_pop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
